sram_bank_access_ctrl: RTL and testbench
========================================

// Module: sram_bank_access_ctrl
// PURPOSE
//  Requester-side controller for the single-port SRAM bank wrapper (64-bit word = 4 x 16-bit lanes).
//  Takes independent write and read request streams (valid/ready), arbitrates them onto the bank's
//  addr/cen/wen/data port (one access per cycle), and captures read data one cycle after issue.
//  Buffers returned data in a credit-protected FIFO, so reads never overflow under rd_data_ready backpressure.
// PARAMETERS
//  ADDR_W         8  bank word-address width
//  DATA_W         16 lane width
//  FW             4  lanes per SRAM word (FW*DATA_W = 64)
//  RD_FIFO_DEPTH  4  read-return FIFO entries; power of 2, >=3 (needed for 1 read/cycle sustained)
// PORTS
//  clk                clk_en, all regs  input   1          clock
//  rst_n              input   1                  async active-low reset
//  clk_en             input   1                  global enable; low = freeze all state, no bank access
//  wr_req_valid       input   1                  write request present
//  wr_req_ready       output  1                  write accepted this cycle
//  wr_addr            input   ADDR_W             write word address
//  wr_data            input   [FW][DATA_W]       write word, lane 0 = bits [15:0] at bank
//  rd_req_valid       input   1                  read request present
//  rd_req_ready       output  1                  read accepted (issued to bank) this cycle
//  rd_addr            input   ADDR_W             read word address
//  rd_data_valid      output  1                  FIFO head valid
//  rd_data_ready      input   1                  consumer takes FIFO head
//  rd_data            output  [FW][DATA_W]       FIFO head word
//  mem_addr_in_bank   output  ADDR_W             to bank
//  mem_cen_in_bank    output  1                  active-high access enable (bank inverts)
//  mem_wen_in_bank    output  1                  active-high write enable (bank inverts)
//  mem_data_in_bank   output  [FW][DATA_W]       to bank
//  mem_data_out_bank  input   [FW][DATA_W]       from bank, valid 1 cycle after read access
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; inflight=0; last_grant=READ.
//  - Reset mid-operation discards inflight read and FIFO contents.
//  - rd_eligible = rd_req_valid & (fifo_count + inflight) < RD_FIFO_DEPTH; ready never depends on rd_data_ready.
//  - Grant (comb, only if clk_en=1): one of write/read.
//      - wr_req_ready=1 iff write granted.
//      - rd_req_ready=1 iff read granted.
//      - Readies may depend combinationally on both valids.
//  - Write grant: cen=1, wen=1, addr=wr_addr, data=wr_data.
//  - Read grant: cen=1, wen=0, addr=rd_addr, data=0.
//  - No grant: cen=wen=0, addr/data=0.
//  - Read latency: issue at edge T (inflight<=1), data sampled from mem_data_out_bank at next edge with
//    clk_en=1 and pushed to FIFO; rd_data_valid rises the cycle after that (min 2 cycles issue->valid).
//  - A new read may issue in the capture cycle (bank Q still holds the previous result).
//  - Writes do not disturb inflight capture.
//  - FIFO: push/pop same cycle legal when non-empty; pop when rd_data_valid&rd_data_ready&clk_en.
//    Pointers wrap mod RD_FIFO_DEPTH; count is $clog2(DEPTH)+1 bits.
//  - clk_en=0: no grants, no push/pop, all regs hold; rd_data_valid/rd_data hold their values.
//  - Read-after-write same address: write granted at T, read at T+1 returns new data (bank ordering).
// CONFIGURATION
//  SRAM_ARB_RR_EN defined: when write and eligible read both present, grant the type NOT equal to
//    last_grant; last_grant updates on every grant. Sole requester always wins.
//  SRAM_ARB_RR_EN undefined: fixed write priority; last_grant register absent; reads starve under
//    continuous writes.
// TESTING
//  1. Write 0x05 <- {0x4444,0x3333,0x2222,0x1111}, then read 0x05, ready=1
//     -> rd_data lane0=0x1111..lane3=0x4444, valid 2 cycles after read issue.
//  2. Back-to-back reads of addr 0..15, rd_data_ready=1 -> rd_req_ready=1 every cycle, 16 words
//     in order, no gaps after first.
//  3. rd_data_ready=0, rd_req_valid held -> exactly RD_FIFO_DEPTH(4) reads issued, rd_req_ready=0
//     after; release -> in-order drain, no loss.
//  4. wr and rd valid every cycle -> RR_EN: grants alternate W,R,W,R starting W; no RR_EN: all W,
//     rd_req_ready=0.
//  5. clk_en=0 for 3 cycles with read inflight -> cen=0, FIFO frozen; clk_en=1 -> captured word
//     correct.
//  6. rst_n low while FIFO holds 2 words + 1 inflight -> all outputs 0 immediately;
//     after release FIFO empty, no stale push.

Source files
------------

// File: rtl/sram_bank_access_ctrl.sv
// Arbitrates write/read request streams onto a single-port SRAM bank; read data is captured one cycle
// after issue into a credit-protected return FIFO. SRAM_ARB_RR_EN selects round-robin instead of write priority.
module sram_bank_access_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 16,
  parameter int FW            = 4,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clk_en_i,
  input  logic                         wr_req_valid_i,
  output logic                         wr_req_ready_o,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [FW-1:0][DATA_W-1:0]    wr_data_i,
  input  logic                         rd_req_valid_i,
  output logic                         rd_req_ready_o,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic                         rd_data_valid_o,
  input  logic                         rd_data_ready_i,
  output logic [FW-1:0][DATA_W-1:0]    rd_data_o,
  output logic [ADDR_W-1:0]            mem_addr_in_bank_o,
  output logic                         mem_cen_in_bank_o,
  output logic                         mem_wen_in_bank_o,
  output logic [FW-1:0][DATA_W-1:0]    mem_data_in_bank_o,
  input  logic [FW-1:0][DATA_W-1:0]    mem_data_out_bank_i
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RD_FIFO_DEPTH);

  typedef logic [FW-1:0][DATA_W-1:0] word_t;

  word_t            fifo_q [RD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, occupancy;
  logic             inflight_q, inflight_d;
  logic             access_en, rd_eligible, wr_grant, rd_grant, push, pop;

  // An inflight read already owns a FIFO slot, so it counts against the credit.
  assign occupancy   = count_q + CNT_W'(inflight_q);
  assign access_en   = clk_en_i & rst_n_i;
  assign rd_eligible = rd_req_valid_i & (occupancy < DEPTH_C);

`ifdef SRAM_ARB_RR_EN
  logic last_wr_q, last_wr_d;

  assign wr_grant = access_en & wr_req_valid_i & (~rd_eligible | ~last_wr_q);
  assign rd_grant = access_en & rd_eligible & ~wr_grant;

  always_comb begin
    last_wr_d = last_wr_q;
    if (wr_grant)      last_wr_d = 1'b1;
    else if (rd_grant) last_wr_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      last_wr_q <= 1'b0;
    else if (clk_en_i) last_wr_q <= last_wr_d;
  end
`else
  assign wr_grant = access_en & wr_req_valid_i;
  assign rd_grant = access_en & rd_eligible & ~wr_req_valid_i;
`endif

  assign wr_req_ready_o = wr_grant;
  assign rd_req_ready_o = rd_grant;

  always_comb begin
    mem_cen_in_bank_o  = 1'b0;
    mem_wen_in_bank_o  = 1'b0;
    mem_addr_in_bank_o = '0;
    mem_data_in_bank_o = '0;
    if (wr_grant) begin
      mem_cen_in_bank_o  = 1'b1;
      mem_wen_in_bank_o  = 1'b1;
      mem_addr_in_bank_o = wr_addr_i;
      mem_data_in_bank_o = wr_data_i;
    end else if (rd_grant) begin
      mem_cen_in_bank_o  = 1'b1;
      mem_addr_in_bank_o = rd_addr_i;
    end
  end

  assign push = clk_en_i & inflight_q;
  assign pop  = clk_en_i & (count_q != '0) & rd_data_ready_i;

  always_comb begin
    inflight_d = rd_grant;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // With clk_en low every register, including the FIFO head, holds.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < RD_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (clk_en_i) begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) fifo_q[wr_ptr_q] <= mem_data_out_bank_i;
    end
  end

  assign rd_data_valid_o = (count_q != '0);
  assign rd_data_o       = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_sram_bank_access_ctrl.sv
// Directed bench for sram_bank_access_ctrl with a behavioural bank and a read-data scoreboard.
module tb_sram_bank_access_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int FW = 4;
  localparam int D  = 4;

  typedef logic [FW-1:0][DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic wr_req_valid = 1'b0, rd_req_valid = 1'b0, rd_data_ready = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  word_t wr_data = '0;
  logic wr_req_ready, rd_req_ready, rd_data_valid;
  word_t rd_data, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic mem_cen, mem_wen;

  always #5 clk = ~clk;

  sram_bank_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FW(FW), .RD_FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
    .wr_req_valid_i(wr_req_valid), .wr_req_ready_o(wr_req_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready), .rd_addr_i(rd_addr),
    .rd_data_valid_o(rd_data_valid), .rd_data_ready_i(rd_data_ready), .rd_data_o(rd_data),
    .mem_addr_in_bank_o(mem_addr), .mem_cen_in_bank_o(mem_cen), .mem_wen_in_bank_o(mem_wen),
    .mem_data_in_bank_o(mem_data_in), .mem_data_out_bank_i(mem_data_out)
  );

  function automatic word_t init_pat(int a);
    return {16'(a) | 16'hD000, 16'(a) | 16'hC000, 16'(a) | 16'hB000, 16'(a) | 16'hA000};
  endfunction

  // Behavioural single-port bank: Q updates only on a read access.
  word_t bank_mem [256];
  bit    written  [256];
  word_t bank_q;
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) begin
        bank_mem[mem_addr] <= mem_data_in;
        written[mem_addr]  <= 1'b1;
      end else begin
        bank_q <= written[mem_addr] ? bank_mem[mem_addr] : init_pat(int'(mem_addr));
      end
    end
  end
  assign mem_data_out = bank_q;

  word_t shadow [256];
  word_t exp_q [$];
  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, pops = 0, first_pop_cyc = 0, last_pop_cyc = 0, gr = 0;
  logic s_wr_rdy, s_rd_rdy, s_vld, s_cen, s_wen;
  logic [AW-1:0] s_addr;
  word_t s_wdata, s_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; samples just before the posedge, then returns at the next negedge.
  task automatic step();
    #4;
    cyc++;
    s_wr_rdy = wr_req_ready; s_rd_rdy = rd_req_ready; s_vld = rd_data_valid;
    s_cen = mem_cen; s_wen = mem_wen; s_addr = mem_addr; s_wdata = mem_data_in; s_rdata = rd_data;
    if (wr_req_ready) shadow[wr_addr] = wr_data;
    if (rd_req_ready) exp_q.push_back(shadow[rd_addr]);
    if (rd_data_valid && rd_data_ready && clk_en && rst_n) begin
      check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
      if (pops == 0) first_pop_cyc = cyc;
      pops++;
      last_pop_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || rd_data_valid) && n < maxc) begin
      step();
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_pat(i);
    @(negedge clk);
    #1;
    check("reset_ctrl", {rd_data_valid, mem_cen, mem_wen, mem_addr, wr_req_ready, rd_req_ready}, 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; clk_en = 1'b1; rd_data_ready = 1'b1;

    // Write then read back the same word; data valid two cycles after issue.
    wr_req_valid = 1'b1; wr_addr = 8'h05; wr_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    step();
    check("t1_wr_gnt", s_wr_rdy, 1'b1);
    check("t1_wr_bank", {s_cen, s_wen, s_addr}, {2'b11, 8'h05});
    check("t1_wr_data", s_wdata, 64'h4444_3333_2222_1111);
    wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_addr = 8'h05;
    step();
    check("t1_rd_gnt", s_rd_rdy, 1'b1);
    check("t1_rd_bank", {s_cen, s_wen, s_addr}, {2'b10, 8'h05});
    check("t1_rd_bank_data", s_wdata, 64'd0);
    rd_req_valid = 1'b0;
    step();
    check("t1_vld_early", s_vld, 1'b0);
    step();
    check("t1_vld_lat2", s_vld, 1'b1);
    check("t1_lane0", s_rdata[0], 16'h1111);
    check("t1_lane3", s_rdata[3], 16'h4444);
    drain(8);

    // Back-to-back reads with a ready consumer.
    pops = 0; gr = 0;
    for (int i = 0; i < 16; i++) begin
      rd_req_valid = 1'b1; rd_addr = AW'(i);
      step();
      if (s_rd_rdy) gr++;
    end
    rd_req_valid = 1'b0;
    check("t2_grants", 64'(gr), 64'd16);
    drain(20);
    check("t2_pops", 64'(pops), 64'd16);
    check("t2_no_gaps", 64'(last_pop_cyc - first_pop_cyc), 64'd15);

    // Stalled consumer: credit limits issued reads to the FIFO depth.
    pops = 0; gr = 0; rd_data_ready = 1'b0; rd_addr = 8'h30;
    for (int i = 0; i < 8; i++) begin
      rd_req_valid = 1'b1;
      step();
      if (s_rd_rdy) begin gr++; rd_addr = rd_addr + 8'd1; end
    end
    check("t3_grants", 64'(gr), 64'(D));
    check("t3_rdy_low", s_rd_rdy, 1'b0);
    check("t3_vld_held", s_vld, 1'b1);
    rd_req_valid = 1'b0; rd_data_ready = 1'b1;
    drain(12);
    check("t3_pops", 64'(pops), 64'(D));

    // Contending writes and reads.
    for (int i = 0; i < 6; i++) begin
      logic [1:0] expg;
      wr_req_valid = 1'b1; wr_addr = 8'h60 + AW'(i); wr_data = {4{16'h7700 + 16'(i)}};
      rd_req_valid = 1'b1; rd_addr = 8'h20 + AW'(i);
`ifdef SRAM_ARB_RR_EN
      expg = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      expg = 2'b10;
`endif
      step();
      check("t4_grant", {s_wr_rdy, s_rd_rdy}, expg);
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    drain(10);

    // clk_en low while a read is inflight.
    pops = 0; rd_req_valid = 1'b1; rd_addr = 8'h60;
    step();
    check("t5_issue", s_rd_rdy, 1'b1);
    clk_en = 1'b0; rd_addr = 8'h61;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_frozen", {s_cen, s_rd_rdy, s_vld}, 3'b000);
    end
    clk_en = 1'b1; rd_req_valid = 1'b0;
    step();
    check("t5_capture_cyc", s_vld, 1'b0);
    step();
    check("t5_valid", s_vld, 1'b1);
    check("t5_pops", 64'(pops), 64'd1);
    drain(6);

    // Reset with two words buffered and one read inflight.
    rd_data_ready = 1'b0; gr = 0;
    for (int i = 0; i < 3; i++) begin
      rd_req_valid = 1'b1; rd_addr = 8'h40 + AW'(i);
      step();
      if (s_rd_rdy) gr++;
    end
    rd_req_valid = 1'b0;
    check("t6_grants", 64'(gr), 64'd3);
    check("t6_fifo_vld", rd_data_valid, 1'b1);
    #1;
    rst_n = 1'b0; wr_req_valid = 1'b1; rd_req_valid = 1'b1; rd_data_ready = 1'b1;
    #1;
    check("t6_rst_ctrl", {rd_data_valid, mem_cen, mem_wen, mem_addr, wr_req_ready, rd_req_ready}, 64'd0);
    check("t6_rst_rd_data", rd_data, 64'd0);
    check("t6_rst_mem_data", mem_data_in, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_stale", s_vld, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
